param_voting_machine: RTL and testbench
=======================================

Name: param_voting_machine

Overview:
- Generalised voting machine with NUM_CAND candidate buttons and CNT_W-bit saturating tallies.
- Per-button press qualification, a one-ballot-per-press lockout FSM, rejection of simultaneous presses, a results-browse mode and a registered winner/tie output.
- Top-level block; drives the board LEDs directly from the candidate buttons and the mode switch.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (2..16)
- CNT_W, 8, width of each candidate tally and of led
- PRESS_CYCLES, 10, consecutive high cycles that qualify a press (>=1)
- ACK_CYCLES, 100, cycles the vote-acknowledge pattern is held (>=1)
- TOT_W, CNT_W+$clog2(NUM_CAND), width of total_votes (derived)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- mode  in  1  0 = voting, 1 = results
- button  in  NUM_CAND  raw candidate buttons, synchronous to clock
- led  out  CNT_W  display
- vote_ack  out  1  one-cycle pulse when a ballot is counted
- vote_reject  out  1  one-cycle pulse when a simultaneous press is rejected
- winner  out  $clog2(NUM_CAND)  index of the leading candidate
- tie  out  1  more than one candidate holds the maximum tally
- total_votes  out  TOT_W  count of accepted ballots, saturating

Behaviour:
- Reset: all tallies, total_votes, led, vote_ack, vote_reject, winner, sel and qualifier counters = 0; tie = 1; FSM = IDLE.
- Qualifier, per button:
  - Counter increments while the button is high and clears while it is low.
  - On reaching PRESS_CYCLES it emits a one-cycle pulse valid[i].
  - No further pulse until the button has gone low.
  - Pulse appears PRESS_CYCLES cycles after the first high sample.
- FSM states: IDLE, ACK, WAIT_REL. The FSM runs only when mode = 0.
- IDLE, exactly one valid[i] pulse:
  - tally[i] += 1, saturating at 2^CNT_W-1.
  - total_votes += 1, saturating.
  - vote_ack = 1 on the next cycle.
  - Go to ACK.
- IDLE, two or more valid pulses in the same cycle: no tally change; vote_reject = 1 next cycle; go to WAIT_REL.
- ACK: led = all ones for ACK_CYCLES cycles, then go to WAIT_REL. Valid pulses are ignored.
- WAIT_REL: go to IDLE on the first cycle in which button == 0. Valid pulses are ignored.
- Voting mode, IDLE/WAIT_REL: led = 0.
- A saturated tally still produces vote_ack and still increments total_votes unless total_votes is itself saturated.
- Results mode (mode = 1):
  - FSM is forced to IDLE on the next cycle; no counting.
  - valid[i] sets sel = i; with multiple simultaneous pulses, the lowest index wins.
  - led = tally[sel], registered with one cycle latency.
- Mode switch: 1->0 mid-browse leaves sel unchanged. 0->1 during ACK aborts the ACK immediately, and the ballot already counted stays counted.
- Winner/tie, registered, updated every cycle:
  - winner = lowest index holding the maximum tally.
  - tie = 1 if two or more candidates hold that maximum; all-zero tallies give winner = 0, tie = 1.
  - Latency: one cycle after the tally update.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). Tallies are lost by design.

Decomposition:
- Package vm_pkg:
  - FSM state enum (IDLE, ACK, WAIT_REL).
  - Mode constants MODE_VOTE = 0, MODE_RESULT = 1.
  - Function clog2_min1 for index widths.
- Sub-module vm_button_qual (parameter PRESS_CYCLES; ports clock, reset, button, valid), instantiated NUM_CAND times via generate.
- Tallies, FSM, display mux and winner logic stay in the top module.

Test Plan (PRESS_CYCLES=4, ACK_CYCLES=3, NUM_CAND=4, CNT_W=8):
- Hold button[2] high 10 cycles in mode 0 -> one vote_ack 5 cycles after the press, tally[2]=1, total_votes=1, led=0xFF for 3 cycles then 0, winner=2, tie=0.
- button[0] and button[3] go high in the same cycle -> vote_reject pulse, no tally change, no vote_ack; a press after both are released counts normally.
- Pulse button[1] for 3 cycles (shorter than PRESS_CYCLES) -> no vote. Hold button[1] continuously for 50 cycles -> exactly one vote.
- Cast 300 votes on button[0] with CNT_W=8 -> tally[0]=255, total_votes=300, vote_ack on every ballot.
- Votes 2,2,0,1 on candidates 0..3, then mode=1 and press button[1] -> led=2 after qualification plus 1 cycle, winner=0, tie=1.
- Drop reset to 0 during ACK -> all outputs at reset values in the same cycle. After reset is released, a new press counts from tally 0.

Source files
------------

// File: rtl/vm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vm_pkg                                                                      |
// | Shared FSM states, mode encodings and width helper for the voting machine.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_REL = 2'd2
    } vm_state_e;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vm_button_qual.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vm_button_qual                                                              |
// | Emits one valid pulse once a button has been high PRESS_CYCLES cycles.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vm_button_qual
    import vm_pkg::*;
#(
    parameter int PRESS_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic valid
);

    localparam int CW = clog2_min1(PRESS_CYCLES + 1);
    localparam logic [CW-1:0] c_press_last = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] c_press_max  = CW'(PRESS_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_valid;

    // Counter parks at PRESS_CYCLES so a held button cannot re-trigger.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (!button) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (r_cnt != c_press_max) begin
            r_cnt   <= r_cnt + CW'(1);
            r_valid <= (r_cnt == c_press_last);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/param_voting_machine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_voting_machine                                                        |
// | NUM_CAND-button voting machine: tallies, lockout FSM, browse, winner/tie.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module param_voting_machine
    import vm_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int PRESS_CYCLES = 10,
    parameter int ACK_CYCLES   = 100,
    parameter int TOT_W        = CNT_W + $clog2(NUM_CAND)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [NUM_CAND-1:0]         button,
    output logic [CNT_W-1:0]            led,
    output logic                        vote_ack,
    output logic                        vote_reject,
    output logic [$clog2(NUM_CAND)-1:0] winner,
    output logic                        tie,
    output logic [TOT_W-1:0]            total_votes
);

    localparam int IDX_W = clog2_min1(NUM_CAND);
    localparam int AW    = clog2_min1(ACK_CYCLES);
    localparam logic [AW-1:0] c_ack_last = AW'(ACK_CYCLES - 1);

    logic [NUM_CAND-1:0] w_valid;
    logic                w_any;
    logic                w_multi;
    logic [IDX_W-1:0]    w_low_idx;

    vm_state_e           r_state;
    vm_state_e           w_state_next;
    logic                w_count;
    logic                w_reject;
    logic [AW-1:0]       r_ack_cnt;

    logic [CNT_W-1:0]    r_tally [NUM_CAND];
    logic [TOT_W-1:0]    r_total;
    logic                r_vote_ack;
    logic                r_vote_reject;
    logic [IDX_W-1:0]    r_sel;
    logic [IDX_W-1:0]    w_sel_next;
    logic [CNT_W-1:0]    r_led;
    logic [IDX_W-1:0]    r_winner;
    logic                r_tie;
    logic [IDX_W-1:0]    w_win;
    logic                w_tie;
    logic [CNT_W-1:0]    w_max;

    genvar g;
    generate
        for (g = 0; g < NUM_CAND; g++) begin : g_qual
            vm_button_qual #(
                .PRESS_CYCLES (PRESS_CYCLES)
            ) u_qual (
                .clock  (clock),
                .reset  (reset),
                .button (button[g]),
                .valid  (w_valid[g])
            );
        end
    endgenerate

    // Lowest pulsing index; a second set bit marks a simultaneous press.
    always_comb begin
        w_any     = |w_valid;
        w_multi   = (w_valid & (w_valid - NUM_CAND'(1))) != '0;
        w_low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (w_valid[i]) w_low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count      = 1'b0;
        w_reject     = 1'b0;
        if (mode == MODE_RESULT) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any && w_multi) begin
                        w_reject     = 1'b1;
                        w_state_next = WAIT_REL;
                    end else if (w_any) begin
                        w_count      = 1'b1;
                        w_state_next = ACK;
                    end
                end
                ACK: begin
                    if (r_ack_cnt == c_ack_last) w_state_next = WAIT_REL;
                end
                WAIT_REL: begin
                    if (button == '0) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ack_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ack_cnt <= (r_state == ACK) ? r_ack_cnt + AW'(1) : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
            r_total       <= '0;
            r_vote_ack    <= 1'b0;
            r_vote_reject <= 1'b0;
        end else begin
            r_vote_ack    <= w_count;
            r_vote_reject <= w_reject;
            if (w_count) begin
                if (r_tally[w_low_idx] != '1)
                    r_tally[w_low_idx] <= r_tally[w_low_idx] + CNT_W'(1);
                if (r_total != '1)
                    r_total <= r_total + TOT_W'(1);
            end
        end
    end

    // Browse selection and display share the same edge so led tracks sel.
    assign w_sel_next = (mode == MODE_RESULT && w_any) ? w_low_idx : r_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel <= '0;
            r_led <= '0;
        end else begin
            r_sel <= w_sel_next;
            if (mode == MODE_RESULT)
                r_led <= r_tally[w_sel_next];
            else
                r_led <= (w_state_next == ACK) ? '1 : '0;
        end
    end

    always_comb begin
        logic v_seen;
        w_max  = r_tally[0];
        w_win  = '0;
        w_tie  = 1'b0;
        v_seen = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (r_tally[i] > w_max) begin
                w_max = r_tally[i];
                w_win = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_tally[i] == w_max) begin
                if (v_seen) w_tie = 1'b1;
                v_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_winner <= '0;
            r_tie    <= 1'b1;
        end else begin
            r_winner <= w_win;
            r_tie    <= w_tie;
        end
    end

    assign led         = r_led;
    assign vote_ack    = r_vote_ack;
    assign vote_reject = r_vote_reject;
    assign winner      = r_winner;
    assign tie         = r_tie;
    assign total_votes = r_total;

endmodule
`default_nettype wire

// File: tb/tb_param_voting_machine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_param_voting_machine                                                     |
// | Directed and randomized checks against a ballot-level reference model.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_param_voting_machine;

    localparam int NUM_CAND     = 4;
    localparam int CNT_W        = 8;
    localparam int PRESS_CYCLES = 4;
    localparam int ACK_CYCLES   = 3;
    localparam int TOT_W        = CNT_W + $clog2(NUM_CAND);
    localparam int IDX_W        = $clog2(NUM_CAND);
    localparam int TAIL         = PRESS_CYCLES + ACK_CYCLES + 3;

    logic                clock  = 1'b0;
    logic                reset  = 1'b0;
    logic                mode   = 1'b0;
    logic [NUM_CAND-1:0] button = '0;
    logic [CNT_W-1:0]    led;
    logic                vote_ack;
    logic                vote_reject;
    logic [IDX_W-1:0]    winner;
    logic                tie;
    logic [TOT_W-1:0]    total_votes;

    param_voting_machine #(
        .NUM_CAND     (NUM_CAND),
        .CNT_W        (CNT_W),
        .PRESS_CYCLES (PRESS_CYCLES),
        .ACK_CYCLES   (ACK_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .button      (button),
        .led         (led),
        .vote_ack    (vote_ack),
        .vote_reject (vote_reject),
        .winner      (winner),
        .tie         (tie),
        .total_votes (total_votes)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int m_tally[NUM_CAND];
    int m_total;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        foreach (m_tally[i]) m_tally[i] = 0;
        m_total = 0;
    endtask

    task automatic model_vote(input int c);
        if (m_tally[c] < (1 << CNT_W) - 1) m_tally[c]++;
        if (m_total < (1 << TOT_W) - 1) m_total++;
    endtask

    // Leader is the lowest index among those holding the highest tally.
    task automatic model_winner(output int w, output int t);
        int mx;
        int hits;
        mx = -1;
        hits = 0;
        w = 0;
        foreach (m_tally[i]) if (m_tally[i] > mx) begin mx = m_tally[i]; w = i; end
        foreach (m_tally[i]) if (m_tally[i] == mx) hits++;
        t = (hits > 1) ? 1 : 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        button = '0;
        mode = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic hold(input logic [NUM_CAND-1:0] mask, input int n, output int acks, output int rejs);
        acks = 0;
        rejs = 0;
        button = mask;
        repeat (n) begin tick(); acks += 32'(vote_ack); rejs += 32'(vote_reject); end
        button = '0;
        repeat (TAIL) begin tick(); acks += 32'(vote_ack); rejs += 32'(vote_reject); end
    endtask

    task automatic browse(input int c, output logic [CNT_W-1:0] val);
        mode = 1'b1;
        button = NUM_CAND'(1) << c;
        repeat (PRESS_CYCLES + 1) tick();
        val = led;
        button = '0;
        tick();
        tick();
    endtask

    initial begin
        int acks, rejs, sum, w, t;
        logic [CNT_W-1:0] val;

        // Reset values
        tick();
        check("rst_led", 32'(led), 0);
        check("rst_ack", 32'(vote_ack), 0);
        check("rst_rej", 32'(vote_reject), 0);
        check("rst_winner", 32'(winner), 0);
        check("rst_tie", 32'(tie), 1);
        check("rst_total", 32'(total_votes), 0);
        reset = 1'b1;
        tick();
        model_clear();

        // Single press on candidate 2 with cycle-exact ack and led window
        button = 4'b0100;
        repeat (PRESS_CYCLES) begin tick(); check("ack_early", 32'(vote_ack), 0); end
        tick();
        model_vote(2);
        check("ack_pulse", 32'(vote_ack), 1);
        check("ack_led0", 32'(led), 32'hFF);
        check("ack_total", 32'(total_votes), 32'(m_total));
        tick();
        check("ack_once", 32'(vote_ack), 0);
        check("ack_led1", 32'(led), 32'hFF);
        check("win_c2", 32'(winner), 2);
        check("tie_c2", 32'(tie), 0);
        tick();
        check("ack_led2", 32'(led), 32'hFF);
        tick();
        check("ack_led_off", 32'(led), 0);
        sum = 0;
        repeat (2) begin tick(); sum += 32'(vote_ack); end
        check("held_no_reack", 32'(sum), 0);
        button = '0;
        repeat (3) tick();

        // Simultaneous press is rejected, then a clean press counts
        hold(4'b1001, 6, acks, rejs);
        check("dual_rej", 32'(rejs), 1);
        check("dual_noack", 32'(acks), 0);
        check("dual_total", 32'(total_votes), 32'(m_total));
        hold(4'b0001, 6, acks, rejs);
        model_vote(0);
        check("after_rej_ack", 32'(acks), 1);
        check("after_rej_total", 32'(total_votes), 32'(m_total));

        // Short press ignored, long press counted once
        hold(4'b0010, PRESS_CYCLES - 1, acks, rejs);
        check("short_noack", 32'(acks), 0);
        hold(4'b0010, 50, acks, rejs);
        model_vote(1);
        check("long_one_ack", 32'(acks), 1);
        check("long_total", 32'(total_votes), 32'(m_total));

        // Saturating tally, non-saturating total
        do_reset();
        sum = 0;
        for (int k = 0; k < 300; k++) begin
            hold(4'b0001, PRESS_CYCLES, acks, rejs);
            sum += acks;
            model_vote(0);
        end
        check("sat_acks", 32'(sum), 300);
        check("sat_total", 32'(total_votes), 32'(m_total));
        browse(0, val);
        check("sat_tally0", 32'(val), 32'(m_tally[0]));
        mode = 1'b0;
        tick();

        // Votes 2,2,0,1 then browse candidate 1
        do_reset();
        foreach (m_tally[c]) begin
            int v;
            v = (c == 0 || c == 1) ? 2 : (c == 2 ? 0 : 1);
            repeat (v) begin
                hold(NUM_CAND'(1) << c, PRESS_CYCLES + 1, acks, rejs);
                model_vote(c);
            end
        end
        browse(1, val);
        model_winner(w, t);
        check("browse_led1", 32'(val), 32'(m_tally[1]));
        check("browse_winner", 32'(winner), 32'(w));
        check("browse_tie", 32'(tie), 32'(t));
        mode = 1'b0;
        tick();

        // Asynchronous reset in the middle of ACK
        button = 4'b0100;
        repeat (PRESS_CYCLES + 1) tick();
        check("pre_rst_ack", 32'(vote_ack), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_led", 32'(led), 0);
        check("arst_ack", 32'(vote_ack), 0);
        check("arst_total", 32'(total_votes), 0);
        check("arst_winner", 32'(winner), 0);
        check("arst_tie", 32'(tie), 1);
        button = '0;
        tick();
        reset = 1'b1;
        tick();
        model_clear();
        hold(4'b1000, PRESS_CYCLES + 1, acks, rejs);
        model_vote(3);
        model_winner(w, t);
        check("post_rst_ack", 32'(acks), 1);
        check("post_rst_total", 32'(total_votes), 32'(m_total));
        check("post_rst_winner", 32'(winner), 32'(w));
        check("post_rst_tie", 32'(tie), 32'(t));

        // Randomized ballots, single and simultaneous presses
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int c1, c2, n;
            logic [NUM_CAND-1:0] mask;
            c1 = int'($urandom_range(0, NUM_CAND - 1));
            n  = int'($urandom_range(1, 8));
            mask = NUM_CAND'(1) << c1;
            if ($urandom_range(0, 4) == 0) begin
                c2 = (c1 + 1 + int'($urandom_range(0, NUM_CAND - 2))) % NUM_CAND;
                mask = mask | (NUM_CAND'(1) << c2);
            end
            hold(mask, n, acks, rejs);
            if (n >= PRESS_CYCLES && $countones(mask) == 1) model_vote(c1);
            check("rnd_ack", 32'(acks), (n >= PRESS_CYCLES && $countones(mask) == 1) ? 1 : 0);
            check("rnd_rej", 32'(rejs), (n >= PRESS_CYCLES && $countones(mask) > 1) ? 1 : 0);
        end
        model_winner(w, t);
        check("rnd_total", 32'(total_votes), 32'(m_total));
        check("rnd_winner", 32'(winner), 32'(w));
        check("rnd_tie", 32'(tie), 32'(t));
        for (int c = 0; c < NUM_CAND; c++) begin
            browse(c, val);
            check("rnd_tally", 32'(val), 32'(m_tally[c]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
